plru_tree_way_select: RTL and testbench
=======================================

// Module: plru_tree_way_select
// PURPOSE
//  Tree pseudo-LRU replacement-policy stage for the set-associative cache.
//  Holds one PLRU tree per cache set, updates it on every way access and
//  produces the one-hot victim way for the addressed set. Its one-hot
//  way_select feeds the cache's one-hot-to-binary encoder directly
//  downstream, which yields the way index for the tag/data memories.
// PARAMETERS
//  N_WAYS      4  ways per set; power of 2, >= 2
//  LINE_OFF_W  4  set-index width; 2**LINE_OFF_W sets
//  NWAY_W      2  $clog2(N_WAYS); derived, never overridden
// PORTS
//  clk         in   1           clock; all state on rising edge
//  reset       in   1           synchronous, active-high
//  write_en    in   1           access strobe: update tree of line_addr
//  way_hit     in   N_WAYS      one-hot accessed way (hit or refilled)
//  line_addr   in   LINE_OFF_W  set index for both update and select
//  way_select  out  N_WAYS      one-hot victim way of set line_addr
// BEHAVIOUR
//  - State: per set, N_WAYS-1 bits b[1..N_WAYS-1], heap-indexed. Node n
//    has children 2n (lower ways) and 2n+1 (upper ways). Leaf node
//    N_WAYS+k is way k.
//  - Victim walk: start at n=1; if b[n]==0 go to 2n, else 2n+1; repeat
//    NWAY_W times. way_select = one-hot of (leaf - N_WAYS). Exactly one bit
//    is always set; never all-zero.
//  - Update (write_en=1 at clock edge): for every node on the path to the
//    accessed way w, set b[n]=1 if w lies in the lower subtree of n, else
//    0 (point away from w). Nodes off the path keep their value. Only the
//    set at line_addr changes.
//  - way_hit decoding: all-zero with write_en=1 -> no update. More than
//    one bit set is illegal; the lowest set bit is used
//    (deterministic, no X).
//  - Reset: all tree bits of all sets cleared in one cycle -> way_select =
//    {{N_WAYS-1{1'b0}},1'b1} (way 0) for every set. Reset wins over a
//    simultaneous write_en. Reset mid-sequence discards all history.
//  - Latency (default build): way_select combinational from the current
//    state and line_addr. An update is visible from the cycle after the
//    write_en edge. Same-cycle write_en and read of the same set
//    returns the pre-update victim.
//  - No handshake back-pressure: write_en is accepted every cycle,
//    including back-to-back updates to the same set.
// CONFIGURATION
//  - PLRU_SELECT_REG_EN defined: way_select is registered. It presents the
//    victim of the line_addr sampled at the previous edge, computed from
//    tree state including any update at that edge. 1-cycle latency. Output
//    reset value is way 0 (one-hot bit 0).
//  - PLRU_SELECT_REG_EN undefined: combinational output as above.
// TESTING  (N_WAYS=4, LINE_OFF_W=4, default build unless noted)
//  1 reset, then any line_addr -> way_select=4'b0001
//  2 write_en, line 3, way_hit=0001 -> next cycle line 3: 4'b0100,
//    line 5: 4'b0001
//  3 line 3 accesses way0, way2, way1, way3 back-to-back -> way_select
//    after each: 0100, 0010, 1000, 0001
//  4 write_en with way_hit=0000 -> tree unchanged; way_hit=0110 acts as
//    0010
//  5 reset pulsed mid-sequence, same cycle as write_en -> every set
//    returns 4'b0001
//  6 PLRU_SELECT_REG_EN: repeat 2 -> 4'b0100 appears one cycle later
//    than default; reset value 4'b0001

Source files
------------

// File: rtl/plru_tree_way_select_if.sv
// Access/victim bundle between the cache controller and the tree-PLRU stage.
// master drives the access strobe and set index; slave returns the one-hot victim.
interface plru_tree_way_select_if #(
  parameter int N_WAYS     = 4,
  parameter int LINE_OFF_W = 4
);
  logic                  write_en;
  logic [N_WAYS-1:0]     way_hit;
  logic [LINE_OFF_W-1:0] line_addr;
  logic [N_WAYS-1:0]     way_select;

  modport master (
    output write_en,
    output way_hit,
    output line_addr,
    input  way_select
  );

  modport slave (
    input  write_en,
    input  way_hit,
    input  line_addr,
    output way_select
  );
endinterface

// File: rtl/plru_tree_way_select.sv
// Per-set tree pseudo-LRU: updates on every access, emits one-hot victim of line_addr; no backpressure.
// Latency: combinational select, or 1 cycle registered when PLRU_SELECT_REG_EN is defined.
module plru_tree_way_select #(
  parameter int N_WAYS     = 4,
  parameter int LINE_OFF_W = 4
) (
  input logic                    clk,
  input logic                    reset,
  plru_tree_way_select_if.slave  plru
);

  localparam int NWAY_W = $clog2(N_WAYS);
  localparam int N_SETS = 1 << LINE_OFF_W;

  // Heap-indexed node bits b[1..N_WAYS-1]; bit value 1 steers toward the upper subtree.
  typedef logic [N_WAYS-1:1] tree_t;

  tree_t             tree_q [N_SETS];
  logic              hit_vld;
  logic [NWAY_W-1:0] hit_idx;
  tree_t             cur_tree;

  // Walk from the root following the node bits; the leaf offset is the victim way.
  function automatic logic [N_WAYS-1:0] victim_of(input tree_t b);
    logic [NWAY_W:0] node;
    node = (NWAY_W+1)'(1);
    for (int l = 0; l < NWAY_W; l++) begin
      node = {node[NWAY_W-1:0], b[node[NWAY_W-1:0]]};
    end
    return N_WAYS'(1) << node[NWAY_W-1:0];
  endfunction

  // Point every node on the path to way w away from w; off-path nodes keep their value.
  function automatic tree_t tree_touch(input tree_t b, input logic [NWAY_W-1:0] w);
    tree_t           nb;
    logic [NWAY_W:0] node;
    logic            dir;
    nb   = b;
    node = (NWAY_W+1)'(1);
    for (int l = 0; l < NWAY_W; l++) begin
      dir                     = w[NWAY_W-1-l];
      nb[node[NWAY_W-1:0]]    = ~dir;
      node                    = {node[NWAY_W-1:0], dir};
    end
    return nb;
  endfunction

  // Lowest set bit wins so an illegal multi-hot access stays deterministic.
  always_comb begin
    hit_vld = |plru.way_hit;
    hit_idx = '0;
    for (int k = N_WAYS - 1; k >= 0; k--) begin
      if (plru.way_hit[k]) begin
        hit_idx = NWAY_W'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < N_SETS; s++) begin
        tree_q[s] <= '0;
      end
    end else if (plru.write_en && hit_vld) begin
      tree_q[plru.line_addr] <= tree_touch(tree_q[plru.line_addr], hit_idx);
    end
  end

  assign cur_tree = tree_q[plru.line_addr];

`ifdef PLRU_SELECT_REG_EN
  logic [N_WAYS-1:0] sel_q;
  tree_t             nxt_tree;

  // Registered select must include an update landing on the same edge.
  always_comb begin
    nxt_tree = cur_tree;
    if (plru.write_en && hit_vld) begin
      nxt_tree = tree_touch(cur_tree, hit_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= N_WAYS'(1);
    end else begin
      sel_q <= victim_of(nxt_tree);
    end
  end

  assign plru.way_select = sel_q;
`else
  assign plru.way_select = victim_of(cur_tree);
`endif

endmodule

// File: tb/tb_plru_tree_way_select.sv
// Directed self-checking bench for plru_tree_way_select (N_WAYS=4, LINE_OFF_W=4).
// Honours PLRU_SELECT_REG_EN for latency-specific scenarios.
module tb_plru_tree_way_select;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  plru_tree_way_select_if #(.N_WAYS(4), .LINE_OFF_W(4)) bus ();

  plru_tree_way_select #(.N_WAYS(4), .LINE_OFF_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .plru  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.write_en = 1'b0;
    bus.way_hit = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic access(input logic [3:0] line, input logic [3:0] hit);
    bus.line_addr = line;
    bus.way_hit   = hit;
    bus.write_en  = 1'b1;
    tick();
    bus.write_en  = 1'b0;
    bus.way_hit   = '0;
  endtask

  task automatic read_sel(input logic [3:0] line, output logic [3:0] sel);
    bus.line_addr = line;
    bus.write_en  = 1'b0;
`ifdef PLRU_SELECT_REG_EN
    tick();
`else
    #1;
`endif
    sel = bus.way_select;
  endtask

  task automatic test_reset();
    logic [3:0] sel;
    logic [3:0] lines [4];
    lines = '{4'd0, 4'd3, 4'd5, 4'd15};
    do_reset();
    foreach (lines[i]) begin
      read_sel(lines[i], sel);
      checks++;
      if (sel !== 4'b0001) begin
        failures++;
        $display("FAIL reset_sel line=%0d got=%b exp=0001", lines[i], sel);
      end
    end
  endtask

  task automatic test_single_update();
    logic [3:0] sel;
    do_reset();
    access(4'd3, 4'b0001);
    read_sel(4'd3, sel);
    checks++;
    if (sel !== 4'b0100) begin
      failures++;
      $display("FAIL single_update_line3 got=%b exp=0100", sel);
    end
    read_sel(4'd5, sel);
    checks++;
    if (sel !== 4'b0001) begin
      failures++;
      $display("FAIL single_update_line5 got=%b exp=0001", sel);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] hits [4];
    logic [3:0] exps [4];
    hits = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};
    exps = '{4'b0100, 4'b0010, 4'b1000, 4'b0001};
    do_reset();
    bus.line_addr = 4'd3;
    bus.write_en  = 1'b1;
    foreach (hits[i]) begin
      bus.way_hit = hits[i];
      tick();
      checks++;
      if (bus.way_select !== exps[i]) begin
        failures++;
        $display("FAIL back_to_back step=%0d got=%b exp=%b", i, bus.way_select, exps[i]);
      end
    end
    bus.write_en = 1'b0;
    bus.way_hit  = '0;
  endtask

  task automatic test_hit_decode();
    logic [3:0] sel;
    do_reset();
    access(4'd3, 4'b0100);
    read_sel(4'd3, sel);
    checks++;
    if (sel !== 4'b0001) begin
      failures++;
      $display("FAIL decode_setup got=%b exp=0001", sel);
    end
    access(4'd3, 4'b0110);
    read_sel(4'd3, sel);
    checks++;
    if (sel !== 4'b1000) begin
      failures++;
      $display("FAIL decode_multi_hot got=%b exp=1000", sel);
    end
    access(4'd3, 4'b0000);
    read_sel(4'd3, sel);
    checks++;
    if (sel !== 4'b1000) begin
      failures++;
      $display("FAIL decode_zero_hit got=%b exp=1000", sel);
    end
    read_sel(4'd4, sel);
    checks++;
    if (sel !== 4'b0001) begin
      failures++;
      $display("FAIL decode_other_set got=%b exp=0001", sel);
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] sel;
    logic [3:0] lines [4];
    lines = '{4'd3, 4'd5, 4'd15, 4'd0};
    do_reset();
    access(4'd3, 4'b0001);
    access(4'd5, 4'b0010);
    access(4'd15, 4'b1000);
    bus.line_addr = 4'd3;
    bus.way_hit   = 4'b0100;
    bus.write_en  = 1'b1;
    reset         = 1'b1;
    tick();
    reset         = 1'b0;
    bus.write_en  = 1'b0;
    bus.way_hit   = '0;
    foreach (lines[i]) begin
      read_sel(lines[i], sel);
      checks++;
      if (sel !== 4'b0001) begin
        failures++;
        $display("FAIL mid_reset line=%0d got=%b exp=0001", lines[i], sel);
      end
    end
  endtask

`ifdef PLRU_SELECT_REG_EN
  task automatic test_reg_latency();
    do_reset();
    bus.line_addr = 4'd3;
    tick();
    checks++;
    if (bus.way_select !== 4'b0001) begin
      failures++;
      $display("FAIL reg_reset_value got=%b exp=0001", bus.way_select);
    end
    bus.way_hit  = 4'b0001;
    bus.write_en = 1'b1;
    #1;
    checks++;
    if (bus.way_select !== 4'b0001) begin
      failures++;
      $display("FAIL reg_before_edge got=%b exp=0001", bus.way_select);
    end
    tick();
    bus.write_en  = 1'b0;
    bus.way_hit   = '0;
    bus.line_addr = 4'd5;
    #1;
    checks++;
    if (bus.way_select !== 4'b0100) begin
      failures++;
      $display("FAIL reg_after_edge got=%b exp=0100", bus.way_select);
    end
    tick();
    checks++;
    if (bus.way_select !== 4'b0001) begin
      failures++;
      $display("FAIL reg_line_switch got=%b exp=0001", bus.way_select);
    end
  endtask
`else
  task automatic test_same_cycle();
    do_reset();
    bus.line_addr = 4'd3;
    bus.way_hit   = 4'b0001;
    bus.write_en  = 1'b1;
    #1;
    checks++;
    if (bus.way_select !== 4'b0001) begin
      failures++;
      $display("FAIL same_cycle_pre got=%b exp=0001", bus.way_select);
    end
    tick();
    bus.write_en = 1'b0;
    bus.way_hit  = '0;
    #1;
    checks++;
    if (bus.way_select !== 4'b0100) begin
      failures++;
      $display("FAIL same_cycle_post got=%b exp=0100", bus.way_select);
    end
  endtask
`endif

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.write_en  = 1'b0;
    bus.way_hit   = '0;
    bus.line_addr = '0;
    tick();
    tick();
    test_reset();
    test_single_update();
    test_back_to_back();
    test_hit_decode();
    test_mid_reset();
`ifdef PLRU_SELECT_REG_EN
    test_reg_latency();
`else
    test_same_cycle();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
